// File: rtl/reg_file_rd_pkg.sv
// Shared miniRISC register-file constants: data width, address width and
// the hard-wired zero register index.
package reg_file_rd_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_NUM_REGS = 2 ** RF_ADDR_W;
    localparam int RF_ZERO_IDX = 0;

    // Index of the link register targeted by jump-and-link write-back.
    localparam int RF_LINK_IDX = RF_NUM_REGS - 1;

endpackage : reg_file_rd_pkg

// File: rtl/reg_file_rd_scoreboard.sv
// Register scoreboard: one busy bit per register, set by decode reservations,
// cleared by write-back, and looked up by both read ports to raise stall.
module reg_scoreboard
    import reg_file_rd_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              rs_byp,
    input  logic              rt_byp,
    output logic              stall
);

    localparam int                NUM_REGS  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_IDX);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                rs_hazard;
    logic                rt_hazard;

    // Clear first, then set: a reservation landing on the register being
    // written back this cycle wins and the register stays busy.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_en && (rsv_addr != ZERO_ADDR)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[ZERO_ADDR] = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A busy source whose value is arriving on the write-back bus this cycle
    // is satisfied by the bypass and must not hold decode.
    assign rs_hazard = busy_q[rs_addr] && !rs_byp;
    assign rt_hazard = busy_q[rt_addr] && !rt_byp;
    assign stall     = rs_hazard || rt_hazard;

endmodule : reg_scoreboard

// File: rtl/reg_file_rd.sv
// Two-read, one-write register file with write-back bypass and a scoreboard
// that stalls decode on reads of registers still awaiting write-back.
module reg_file_rd
    import reg_file_rd_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              stall
);

    localparam int                NUM_REGS  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_IDX);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              wr_live;
    logic              rs_byp;
    logic              rt_byp;

    assign wr_live = wr_en && (wr_addr != ZERO_ADDR);
    assign rs_byp  = wr_live && (wr_addr == rs_addr);
    assign rt_byp  = wr_live && (wr_addr == rt_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the array is reset because architectural state must read as zero after reset; a scratch RAM would skip this.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_live) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Register 0 is forced to zero on read as well as never written, so the
    // read path does not depend on the array entry being initialised.
    always_comb begin
        rs_data = '0;
        if (rs_byp) begin
            rs_data = wr_data;
        end else if (rs_addr != ZERO_ADDR) begin
            rs_data = regs_q[rs_addr];
        end
    end

    always_comb begin
        rt_data = '0;
        if (rt_byp) begin
            rt_data = wr_data;
        end else if (rt_addr != ZERO_ADDR) begin
            rt_data = regs_q[rt_addr];
        end
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_byp   (rs_byp),
        .rt_byp   (rt_byp),
        .stall    (stall)
    );

endmodule : reg_file_rd

// File: tb/tb_reg_file_rd.sv
// Directed bench for reg_file_rd: a register/busy-bit model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_reg_file_rd;

    logic        clk;
    logic        rst;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        stall;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          model_valid = 0;

    reg_file_rd dut (
        .clk      (clk),
        .rst      (rst),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .stall    (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Architectural model: what a read of register a must return this cycle.
    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic model_stall();
        logic rs_ok, rt_ok;
        rs_ok = !m_busy[rs_addr] || (wr_en && wr_addr == rs_addr && rs_addr != 5'd0);
        rt_ok = !m_busy[rt_addr] || (wr_en && wr_addr == rt_addr && rt_addr != 5'd0);
        return !(rs_ok && rt_ok);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_busy[i] = 1'b0;
            end
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (wr_en && wr_addr != 5'd0) m_regs[wr_addr] = wr_data;
            if (wr_en) m_busy[wr_addr] = 1'b0;
            if (rsv_en && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_rs_data", rs_data, model_read(rs_addr));
            check("model_rt_data", rt_data, model_read(rt_addr));
            check("model_stall", {31'h0, stall}, {31'h0, model_stall()});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one cycle of inputs, then wait to the mid-cycle sample point.
    task automatic drv(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] ra,
                       input logic [4:0] a, input logic [4:0] b);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = ra;
        rs_addr = a; rt_addr = b;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        rs_addr = '0; rt_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        step();
        step();
        rst = 1'b0;

        drv(0, 0, 0, 0, 0, 3, 31);
        check("reset_rs_data", rs_data, 32'h0);
        check("reset_rt_data", rt_data, 32'h0);
        check("reset_stall", {31'h0, stall}, 32'h0);
        step();

        drv(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        step();
        drv(0, 0, 0, 0, 0, 5, 0);
        check("write_read_r5", rs_data, 32'hDEADBEEF);
        step();

        drv(1, 0, 32'h12345678, 0, 0, 0, 0);
        check("r0_write_cycle_rs", rs_data, 32'h0);
        step();
        drv(0, 0, 0, 0, 0, 0, 0);
        check("r0_rs_data", rs_data, 32'h0);
        check("r0_rt_data", rt_data, 32'h0);
        check("r0_stall", {31'h0, stall}, 32'h0);
        step();

        drv(1, 7, 32'hA5A5A5A5, 0, 0, 5, 7);
        check("bypass_rt_r7", rt_data, 32'hA5A5A5A5);
        check("bypass_rs_r5_unaffected", rs_data, 32'hDEADBEEF);
        step();

        drv(0, 0, 0, 1, 31, 0, 0);
        step();
        drv(0, 0, 0, 0, 0, 31, 0);
        check("hazard_r31_stall", {31'h0, stall}, 32'h1);
        step();
        drv(1, 31, 32'h400, 0, 0, 31, 0);
        check("hazard_r31_bypass_stall", {31'h0, stall}, 32'h0);
        check("hazard_r31_bypass_data", rs_data, 32'h400);
        step();
        drv(0, 0, 0, 0, 0, 31, 0);
        check("hazard_r31_cleared", {31'h0, stall}, 32'h0);
        check("hazard_r31_data", rs_data, 32'h400);
        step();

        drv(0, 0, 0, 1, 9, 0, 0);
        step();
        drv(1, 9, 32'h99, 1, 9, 0, 0);
        step();
        drv(0, 0, 0, 0, 0, 9, 0);
        check("rsv_wr_same_stall", {31'h0, stall}, 32'h1);
        check("rsv_wr_same_data", rs_data, 32'h99);
        step();
        drv(1, 9, 32'h1, 0, 0, 0, 9);
        check("r9_release_stall", {31'h0, stall}, 32'h0);
        step();

        drv(0, 0, 0, 1, 12, 0, 0);
        step();
        drv(0, 0, 0, 0, 0, 12, 12);
        check("same_addr_stall", {31'h0, stall}, 32'h1);
        step();

        drv(0, 0, 0, 1, 13, 0, 0);
        step();
        drv(0, 0, 0, 1, 14, 0, 0);
        step();
        drv(1, 13, 32'h1313, 0, 0, 13, 14);
        check("rt_only_hazard_stall", {31'h0, stall}, 32'h1);
        check("rt_only_hazard_rs_byp", rs_data, 32'h1313);
        step();

        drv(0, 0, 0, 1, 0, 0, 0);
        step();
        drv(0, 0, 0, 0, 0, 0, 0);
        check("rsv_r0_ignored", {31'h0, stall}, 32'h0);
        step();

        drv(1, 3, 32'h33, 0, 0, 0, 0);
        step();
        drv(1, 4, 32'h44, 0, 0, 0, 0);
        step();
        drv(0, 0, 0, 1, 4, 3, 4);
        check("pre_reset_r3", rs_data, 32'h33);
        step();
        drv(0, 0, 0, 0, 0, 3, 4);
        check("pre_reset_r4_stall", {31'h0, stall}, 32'h1);
        step();
        rst = 1'b1;
        drv(1, 3, 32'hFFFF, 1, 5, 0, 0);
        step();
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 3, 4);
        check("mid_reset_r3", rs_data, 32'h0);
        check("mid_reset_r4", rt_data, 32'h0);
        check("mid_reset_stall", {31'h0, stall}, 32'h0);
        step();
        drv(0, 0, 0, 0, 0, 5, 31);
        check("mid_reset_rsv_dropped", {31'h0, stall}, 32'h0);
        check("mid_reset_r31", rt_data, 32'h0);
        step();

        step();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_reg_file_rd
